// File: rtl/fifo_256x512_sync.sv
// Single-clock 256-bit x 512-entry FIFO with standard (registered) read timing,
// registered full/empty flags and a post-reset initialisation window signalled on rdy.
module fifo_256x512_sync #(
   parameter int WIDTH       = 256,
   parameter int DEPTH       = 512,
   parameter int INIT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic             rdy
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = $clog2(INIT_CYCLES + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic [AW:0]      count_next;
   logic [IW-1:0]    init_cnt;
   logic             wr_acc;
   logic             rd_acc;
   logic             rdy_next;

   // full already folds in !rdy after the first post-reset edge; rdy is still
   // gated explicitly because full reads 0 during reset itself.
   always_comb begin
      wr_acc     = wr_en & rdy & ~full;
      rd_acc     = rd_en & rdy & ~empty;
      rdy_next   = rdy | (init_cnt == IW'(INIT_CYCLES - 1));
      count_next = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_next = count + (AW+1)'(1);
         2'b01:   count_next = count - (AW+1)'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_cnt <= '0;
         rdy      <= 1'b0;
      end else if (!rdy) begin
         init_cnt <= init_cnt + IW'(1);
         rdy      <= rdy_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
      end else begin
         if (wr_acc) wptr <= wptr + AW'(1);
         if (rd_acc) rptr <= rptr + AW'(1);
         count <= count_next;
         empty <= (count_next == '0);
         full  <= (count_next == (AW+1)'(DEPTH)) | ~rdy_next;
      end
   end

   // NOTE: the array has no reset so it maps onto block RAM; only dout is cleared.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst)         dout <= '0;
      else if (rd_acc) dout <= mem[rptr];
   end

endmodule

// File: tb/tb_fifo_256x512_sync.sv
// Self-checking bench for fifo_256x512_sync: a fixed vector table for reset/init and
// small handshakes, directed fill/wrap/reset sequences, and random traffic vs a queue model.
module tb_fifo_256x512_sync;

   localparam int W = 256;
   localparam int D = 512;
   localparam int INIT = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         wr_en = 1'b0;
   logic         rd_en = 1'b0;
   logic [W-1:0] dout;
   logic         full;
   logic         empty;
   logic         rdy;

   fifo_256x512_sync dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .rdy   (rdy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural reference: a plain queue plus an init counter.
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout = '0;
   int           m_init = 0;
   bit           m_rdy = 1'b0;
   bit           m_full = 1'b0;
   bit           m_empty = 1'b1;

   typedef struct {
      logic         rst;
      logic         wr;
      logic         rd;
      logic [W-1:0] din;
      logic         e_empty;
      logic         e_full;
      logic         e_rdy;
      logic [W-1:0] e_dout;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
      bit aw, ar;
      if (r) begin
         q.delete();
         m_dout  = '0;
         m_init  = 0;
         m_rdy   = 1'b0;
         m_full  = 1'b0;
         m_empty = 1'b1;
      end else begin
         aw = w && m_rdy && (q.size() < D);
         ar = rd && m_rdy && (q.size() > 0);
         if (ar) m_dout = q.pop_front();
         if (aw) q.push_back(d);
         if (!m_rdy) begin
            m_init++;
            if (m_init == INIT) m_rdy = 1'b1;
         end
         m_empty = (q.size() == 0);
         m_full  = (q.size() == D) || !m_rdy;
      end
   endtask

   // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
   task automatic drive(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
      rst = r; wr_en = w; rd_en = rd; din = d;
      @(posedge clk);
      model_step(r, w, rd, d);
      #1;
      check("dout",  dout,          m_dout);
      check("empty", W'(empty),     W'(m_empty));
      check("full",  W'(full),      W'(m_full));
      check("rdy",   W'(rdy),       W'(m_rdy));
   endtask

   task automatic reset_and_init();
      drive(1, 0, 0, '0);
      drive(1, 0, 0, '0);
      for (int i = 0; i < 40 && !m_rdy; i++) drive(0, 0, 0, '0);
      check("init_rdy", W'(rdy), W'(1));
   endtask

   function automatic vec_t mk(logic r, logic w, logic rd, logic [W-1:0] d,
                               logic ee, logic ef, logic er, logic [W-1:0] ed);
      vec_t v;
      v.rst = r; v.wr = w; v.rd = rd; v.din = d;
      v.e_empty = ee; v.e_full = ef; v.e_rdy = er; v.e_dout = ed;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl[26];
      logic [W-1:0] va, vb, vc, vx;
      logic [W-1:0] val;
      int           wp, rp;

      va = {8{32'hA5A5_0001}};
      vb = {8{32'hB6B6_0002}};
      vc = {8{32'hC7C7_0003}};
      vx = {8{32'hDEAD_BEEF}};

      // Reset, init window (writes/reads ignored), then basic handshakes.
      tbl[0] = mk(1, 0, 0, '0, 1, 0, 0, '0);
      tbl[1] = mk(1, 0, 0, '0, 1, 0, 0, '0);
      for (int i = 2; i <= 16; i++) tbl[i] = mk(0, 0, 0, '0, 1, 1, 0, '0);
      tbl[5]  = mk(0, 1, 0, vx, 1, 1, 0, '0);
      tbl[8]  = mk(0, 1, 1, vx, 1, 1, 0, '0);
      tbl[17] = mk(0, 0, 0, '0, 1, 0, 1, '0);
      tbl[18] = mk(0, 0, 1, '0, 1, 0, 1, '0);
      tbl[19] = mk(0, 1, 0, va, 0, 0, 1, '0);
      tbl[20] = mk(0, 1, 1, vb, 0, 0, 1, va);
      tbl[21] = mk(0, 0, 1, '0, 1, 0, 1, vb);
      tbl[22] = mk(0, 0, 1, '0, 1, 0, 1, vb);
      tbl[23] = mk(0, 1, 1, vc, 0, 0, 1, vb);
      tbl[24] = mk(0, 0, 0, '0, 0, 0, 1, vb);
      tbl[25] = mk(0, 0, 1, '0, 1, 0, 1, vc);

      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
         check($sformatf("tbl%0d_dout", i),  dout,      tbl[i].e_dout);
         check($sformatf("tbl%0d_empty", i), W'(empty), W'(tbl[i].e_empty));
         check($sformatf("tbl%0d_full", i),  W'(full),  W'(tbl[i].e_full));
         check($sformatf("tbl%0d_rdy", i),   W'(rdy),   W'(tbl[i].e_rdy));
      end

      // Streaming with rd_en = ~empty; the model checks order cycle by cycle.
      for (int i = 1; i <= 200; i++) drive(0, 1, !empty, W'(i));
      for (int i = 0; i < 4; i++) drive(0, 0, !empty, '0);

      // Fill to DEPTH, overflow write dropped, drain in order.
      reset_and_init();
      for (int i = 0; i < D; i++) drive(0, 1, 0, W'(i));
      check("fill_full", W'(full), W'(1));
      drive(0, 1, 0, W'(32'hDEAD));
      check("overflow_full", W'(full), W'(1));
      drive(0, 1, 1, W'(32'hDEAD));
      check("full_wr_rd_dout", dout, W'(0));
      check("full_wr_rd_notfull", W'(full), W'(0));
      for (int i = 1; i < D; i++) begin
         drive(0, 0, 1, '0);
         check("drain", dout, W'(i));
      end
      check("drain_empty", W'(empty), W'(1));

      // Reads on empty leave dout alone.
      for (int i = 0; i < 3; i++) drive(0, 0, 1, '0);
      check("empty_read_dout", dout, W'(D - 1));

      // Three rounds of 300 in / 300 out across the pointer wrap.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 300; i++) drive(0, 1, 0, W'(1000 * r + i));
         check("wrap_notempty", W'(empty), W'(0));
         for (int i = 0; i < 300; i++) begin
            drive(0, 0, 1, '0);
            check("wrap_data", dout, W'(1000 * r + i));
         end
         check("wrap_empty", W'(empty), W'(1));
      end

      // Reset with 100 words stored.
      for (int i = 0; i < 100; i++) drive(0, 1, 0, W'(5000 + i));
      drive(1, 0, 0, '0);
      check("midrst_dout", dout, W'(0));
      check("midrst_empty", W'(empty), W'(1));
      check("midrst_rdy", W'(rdy), W'(0));
      for (int i = 0; i < 40 && !m_rdy; i++) drive(0, 0, 0, '0);
      drive(0, 1, 0, vc);
      drive(0, 0, 1, '0);
      check("midrst_first_word", dout, vc);

      // Random traffic in three bias phases, with rare resets.
      for (int ph = 0; ph < 3; ph++) begin
         wp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
         rp = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
         for (int i = 0; i < 1500; i++) begin
            val = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            drive($urandom_range(0, 999) == 0,
                  $urandom_range(0, 99) < wp,
                  $urandom_range(0, 99) < rp,
                  val);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
